// File: rtl/apb_timer_multi.sv
// apb_timer_multi: APB slave with a shared prescaler and NCH counter/compare
// channels. Each channel runs one-shot or periodic, emits a one-cycle trig
// pulse on match, and keeps a sticky MATCH bit that feeds a combined irq.
module apb_timer_multi #(
  parameter int WIDTH  = 8,
  parameter int NCH    = 2,
  parameter int ADDR_W = 5
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [WIDTH-1:0]  PWDATA,
  output logic [WIDTH-1:0]  PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NCH-1:0]    trig,
  output logic              irq
);

  localparam int CW = ADDR_W - 2;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] presc_r;
  logic [WIDTH-1:0] pcnt_r;
  logic [WIDTH-1:0] cmp_r [NCH];
  logic [WIDTH-1:0] cnt_r [NCH];
  logic [NCH-1:0]   en_r;
  logic [NCH-1:0]   mode_r;
  logic [NCH-1:0]   ie_r;
  logic [NCH-1:0]   match_r;
  logic [NCH-1:0]   trig_r;
  logic             irq_r;

  logic [CW-1:0]    sel_ch_s;
  logic [1:0]       off_s;
  logic             mapped_s;
  logic             wr_s;
  logic             wr_presc_s;
  logic [NCH-1:0]   wr_ctrl_s;
  logic [NCH-1:0]   wr_cmp_s;
  logic [NCH-1:0]   wr_cnt_s;
  logic [NCH-1:0]   wr_stat_s;
  logic             tick_s;
  logic [NCH-1:0]   match_s;
  logic [WIDTH-1:0] rd_s;
  logic [WIDTH-1:0] chan_rd_s;
  logic [WIDTH-1:0] prdata_s;

  // Decode the word index into register hits and per-channel write strobes
  always_comb begin
    sel_ch_s   = PADDR[ADDR_W-1:2];
    off_s      = PADDR[1:0];
    if (PADDR == '0) begin
      mapped_s = 1'b1;
    end else if ((sel_ch_s != '0) && (sel_ch_s <= CW'(NCH))) begin
      mapped_s = 1'b1;
    end else begin
      mapped_s = 1'b0;
    end
    wr_s       = PSEL & PENABLE & PWRITE & mapped_s;
    wr_presc_s = wr_s & (PADDR == '0);
    wr_ctrl_s  = '0;
    wr_cmp_s   = '0;
    wr_cnt_s   = '0;
    wr_stat_s  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (wr_s && (sel_ch_s == CW'(c + 1))) begin
        wr_ctrl_s[c] = (off_s == 2'd0);
        wr_cmp_s[c]  = (off_s == 2'd1);
        wr_cnt_s[c]  = (off_s == 2'd2);
        wr_stat_s[c] = (off_s == 2'd3);
      end else begin
        wr_ctrl_s[c] = 1'b0;
        wr_cmp_s[c]  = 1'b0;
        wr_cnt_s[c]  = 1'b0;
        wr_stat_s[c] = 1'b0;
      end
    end
  end

  // Prescaler tick and match detection; a CNT load suppresses the match
  always_comb begin
    tick_s = (pcnt_r == presc_r);
    for (int c = 0; c < NCH; c++) begin
      match_s[c] = tick_s & en_r[c] & (cnt_r[c] == cmp_r[c]) & ~wr_cnt_s[c];
    end
  end

  // Combinational read mux: channel registers OR-ed by hit, then PRESC/zero
  always_comb begin
    chan_rd_s = '0;
    rd_s      = '0;
    for (int c = 0; c < NCH; c++) begin
      rd_s = '0;
      case (off_s)
        2'd0:    rd_s[2:0] = {ie_r[c], mode_r[c], en_r[c]};
        2'd1:    rd_s = cmp_r[c];
        2'd2:    rd_s = cnt_r[c];
        2'd3:    rd_s[0] = match_r[c];
        default: rd_s = '0;
      endcase
      chan_rd_s = chan_rd_s | ((sel_ch_s == CW'(c + 1)) ? rd_s : '0);
    end
    if (PSEL && !PWRITE && mapped_s && (PADDR == '0)) begin
      prdata_s = presc_r;
    end else if (PSEL && !PWRITE && mapped_s) begin
      prdata_s = chan_rd_s;
    end else begin
      prdata_s = '0;
    end
  end

  // Prescaler counter, channel state, sticky status and registered outputs
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      presc_r <= '0;
      pcnt_r  <= '0;
      en_r    <= '0;
      mode_r  <= '0;
      ie_r    <= '0;
      match_r <= '0;
      trig_r  <= '0;
      irq_r   <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        cmp_r[c] <= '0;
        cnt_r[c] <= '0;
      end
    end else begin
      if (wr_presc_s) begin
        presc_r <= PWDATA;
      end
      if (wr_presc_s || tick_s) begin
        pcnt_r <= '0;
      end else begin
        pcnt_r <= pcnt_r + ONE;
      end
      trig_r <= match_s;
      irq_r  <= |(match_r & ie_r);
      for (int c = 0; c < NCH; c++) begin
        // software CTRL write wins over the one-shot self-disable
        if (wr_ctrl_s[c]) begin
          en_r[c]   <= PWDATA[0];
          mode_r[c] <= PWDATA[1];
          ie_r[c]   <= PWDATA[2];
        end else if (match_s[c] && !mode_r[c]) begin
          en_r[c] <= 1'b0;
        end
        if (wr_cmp_s[c]) begin
          cmp_r[c] <= PWDATA;
        end
        if (wr_cnt_s[c]) begin
          cnt_r[c] <= PWDATA;
        end else if (wr_ctrl_s[c] && PWDATA[0] && !en_r[c]) begin
          cnt_r[c] <= '0;
        end else if (match_s[c]) begin
          cnt_r[c] <= '0;
        end else if (tick_s && en_r[c]) begin
          cnt_r[c] <= cnt_r[c] + ONE;
        end
        // hardware set beats a same-cycle write-1-to-clear
        if (match_s[c]) begin
          match_r[c] <= 1'b1;
        end else if (wr_stat_s[c] && PWDATA[0]) begin
          match_r[c] <= 1'b0;
        end
      end
    end
  end

  assign PRDATA  = prdata_s;
  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & ~mapped_s & ~PRESET;
  assign trig    = trig_r;
  assign irq     = irq_r;

endmodule
